// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Used by the fetch stage, its queues and the PC register.
package fetch_pkg;

  localparam int FETCH_XLEN  = 32;
  localparam int FETCH_DEPTH = 4;

  localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 32'h0040_0000;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int FETCH_CNT_W = cnt_w(FETCH_DEPTH);

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: PC input, imem port, decode output.
// master is the fetch stage, slave is its surroundings.
interface fetch_stage_if
  import fetch_pkg::*;
#(
  parameter int XLEN = FETCH_XLEN
);

  logic            pc_valid;
  logic            pc_ready;
  logic [XLEN-1:0] pc;
  logic            flush;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            busy;

  modport master (
    input  pc, pc_valid, flush,
    input  imem_req_ready, imem_rsp_valid,
    input  imem_rsp_data, instr_ready,
    output pc_ready, imem_req_valid,
    output imem_addr, instr_valid,
    output instr, instr_pc, busy
  );

  modport slave (
    output pc, pc_valid, flush,
    output imem_req_ready, imem_rsp_valid,
    output imem_rsp_data, instr_ready,
    input  pc_ready, imem_req_valid,
    input  imem_addr, instr_valid,
    input  instr, instr_pc, busy
  );

endinterface

// File: rtl/fetch_stage_sync_fifo.sv
// Small synchronous FIFO with clear and occupancy count.
// Head data reads as zero while empty.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wr_data,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push && !clear && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset || clear)
    !(push && full && !pop)
  );

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: credit-limited in-order imem reads,
// flush-aware response filtering, PC-tagged decode queue.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int XLEN  = FETCH_XLEN,
  parameter int DEPTH = FETCH_DEPTH
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

  localparam int CW = cnt_w(DEPTH);

  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard_cnt;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   tag_count;
  logic [CW:0]     occ;
  logic            credit_ok;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_drop;
  logic            q_push;
  logic            q_pop;
  logic            tag_full;
  logic            tag_empty;
  logic            q_full;
  logic            q_empty;
  logic [XLEN-1:0] tag;
  fetch_entry_t    q_wr;
  fetch_entry_t    q_rd;

  assign occ       = {1'b0, inflight} + {1'b0, q_count};
  assign credit_ok = occ < (CW+1)'(DEPTH);

  assign req_valid = bus.pc_valid & credit_ok
                   & ~bus.flush & ~reset;
  assign req_fire  = req_valid & bus.imem_req_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.pc_ready       = req_fire;
  assign bus.imem_addr      = {bus.pc[XLEN-1:2], 2'b00};

  assign rsp_drop = bus.flush | (discard_cnt != '0);
  assign q_push   = bus.imem_rsp_valid & ~rsp_drop;
  assign q_pop    = ~q_empty & bus.instr_ready;

  assign q_wr = '{pc: tag, instr: bus.imem_rsp_data};

  assign bus.instr_valid = ~q_empty;
  assign bus.instr       = q_rd.instr;
  assign bus.instr_pc    = q_rd.pc;
  assign bus.busy        = (inflight != '0) | ~q_empty;

  // Outstanding reads and the number of stale responses still due.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight    <= '0;
      discard_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire)
                - CW'(bus.imem_rsp_valid);
      if (bus.flush) begin
        discard_cnt <= inflight - CW'(bus.imem_rsp_valid);
      end else if (bus.imem_rsp_valid && discard_cnt != '0) begin
        discard_cnt <= discard_cnt - CW'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (1'b0),
    .push    (req_fire),
    .pop     (bus.imem_rsp_valid),
    .wr_data (bus.pc),
    .rd_data (tag),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (tag_count)
  );

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.flush),
    .push    (q_push),
    .pop     (q_pop),
    .wr_data (q_wr),
    .rd_data (q_rd),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  a_inflight_ovf: assert property (
    @(posedge clk) disable iff (reset)
    !(req_fire && (inflight == CW'(DEPTH) || tag_full))
  );

  a_inflight_udf: assert property (
    @(posedge clk) disable iff (reset)
    !(bus.imem_rsp_valid && (inflight == '0 || tag_empty))
  );

  a_tag_sync: assert property (
    @(posedge clk) disable iff (reset)
    tag_count == inflight
  );

  a_discard_le: assert property (
    @(posedge clk) disable iff (reset)
    discard_cnt <= inflight
  );

  a_q_ovf: assert property (
    @(posedge clk) disable iff (reset)
    !(q_push && q_full && !q_pop)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a queue-level
// reference model and literal pins on key observations.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } infl_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } mrsp_t;

  logic clk = 1'b0;
  logic reset;

  fetch_stage_if #(.XLEN(32)) bus ();

  fetch_stage #(
    .XLEN  (32),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;
  int drops = 0;
  bit model_ok = 0;

  bit rst_cmd = 1;
  bit pcv_cmd = 0;
  bit rr_cmd = 1;
  bit ir_cmd = 1;
  bit flush_cmd = 0;
  logic [31:0] redirect = 32'h0;
  logic [31:0] pc_reg = FETCH_RESET_PC;

  infl_t        infl[$];
  fetch_entry_t q[$];
  mrsp_t        pend[$];
  logic [31:0]  pops[$];
  logic [31:0]  dut_pops[$];

  logic        s_pr, s_rv, s_iv, s_busy;
  logic [31:0] s_instr, s_ipc, s_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    bit rv, credit, ex_rv, ex_fire;
    logic [31:0] rd;
    infl_t e;
    fetch_entry_t h;
    @(negedge clk);
    rv = !rst_cmd && pend.size() > 0 && pend[0].due == cyc;
    rd = rv ? pend[0].data : 32'h0;
    reset              = rst_cmd;
    bus.pc             = pc_reg;
    bus.pc_valid       = pcv_cmd;
    bus.flush          = flush_cmd;
    bus.imem_req_ready = rr_cmd;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    bus.instr_ready    = ir_cmd;
    #1;
    credit  = (infl.size() + q.size()) < DEPTH;
    ex_rv   = pcv_cmd && credit && !flush_cmd && !rst_cmd;
    ex_fire = ex_rv && rr_cmd;
    s_pr    = bus.pc_ready;
    s_rv    = bus.imem_req_valid;
    s_iv    = bus.instr_valid;
    s_busy  = bus.busy;
    s_instr = bus.instr;
    s_ipc   = bus.instr_pc;
    s_addr  = bus.imem_addr;
    if (model_ok) begin
      chk("pc_ready", 32'(s_pr), 32'(ex_fire));
      chk("req_valid", 32'(s_rv), 32'(ex_rv));
      chk("instr_valid", 32'(s_iv), 32'(q.size() != 0));
      chk("busy", 32'(s_busy),
          32'(infl.size() != 0 || q.size() != 0));
      if (ex_rv) chk("imem_addr", s_addr, pc_reg & ~32'h3);
      if (q.size() != 0) begin
        h = q[0];
        chk("instr_pc", s_ipc, h.pc);
        chk("instr", s_instr, h.instr);
      end
    end
    if (s_iv && ir_cmd && !flush_cmd && !rst_cmd)
      dut_pops.push_back(s_ipc);
    @(posedge clk);
    if (rst_cmd) begin
      infl.delete();
      q.delete();
      pend.delete();
      pc_reg = FETCH_RESET_PC;
      model_ok = 1;
    end else begin
      if (rv) pend.delete(0);
      if (flush_cmd) begin
        if (rv && infl.size() > 0) begin
          infl.delete(0);
          drops++;
        end
        foreach (infl[i]) infl[i].stale = 1'b1;
        q.delete();
        pc_reg = redirect;
      end else begin
        if (ir_cmd && q.size() > 0) begin
          h = q.pop_front();
          pops.push_back(h.pc);
        end
        if (rv && infl.size() > 0) begin
          e = infl.pop_front();
          if (e.stale) drops++;
          else q.push_back('{pc: e.pc, instr: rd});
        end
        if (ex_fire) begin
          infl.push_back('{pc: pc_reg, stale: 1'b0});
          pend.push_back('{due: cyc + lat,
                           data: memf(pc_reg & ~32'h3)});
          pc_reg = pc_reg + 32'd4;
        end
      end
    end
    flush_cmd = 0;
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Run up to n cycles; report the first visible head PC.
  task automatic first_valid(input int n,
                             output int off,
                             output logic [31:0] fpc);
    off = -1;
    fpc = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      tick();
      if (s_iv && off < 0) begin
        off = i;
        fpc = s_ipc;
      end
    end
  endtask

  initial begin
    int off, cnt;
    logic [31:0] fpc, stall_pc;
    reset              = 1'b1;
    bus.pc             = '0;
    bus.pc_valid       = 1'b0;
    bus.flush          = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.instr_ready    = 1'b1;

    // Reset, then streaming with a 1-cycle memory.
    rst_cmd = 1;
    ticks(2);
    rst_cmd = 0;
    pcv_cmd = 1;
    ir_cmd  = 1;
    lat     = 1;
    dut_pops.delete();
    pops.delete();
    off = -1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin
        chk("rst_instr", s_instr, 32'h0);
        chk("rst_instr_pc", s_ipc, 32'h0);
        chk("rst_busy", 32'(s_busy), 32'h0);
      end
      if (s_iv && off < 0) off = i;
      if (s_pr) cnt++;
    end
    chk("stream_latency", 32'(off), 32'd2);
    chk("stream_pr_cnt", 32'(cnt), 32'd12);
    chk("stream_pc0", dut_pops[0], 32'h0040_0000);
    chk("stream_pc1", dut_pops[1], 32'h0040_0004);
    chk("stream_pc2", dut_pops[2], 32'h0040_0008);
    chk("model_pc0", pops[0], 32'h0040_0000);

    // Backpressure: decode stalled, only DEPTH requests go out.
    pcv_cmd = 0;
    ticks(4);
    pcv_cmd = 1;
    ir_cmd  = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_pr) cnt++;
    end
    chk("bp_req_cnt", 32'(cnt), 32'd4);
    ir_cmd = 1;
    dut_pops.delete();
    ticks(12);
    chk("bp_len", 32'(dut_pops.size() >= 8), 32'd1);
    foreach (dut_pops[i])
      chk("bp_order", dut_pops[i],
          32'h0040_0030 + 32'(4 * i));

    // Flush with two requests in flight (3-cycle memory).
    pcv_cmd = 0;
    ticks(6);
    lat = 3;
    pcv_cmd = 1;
    ticks(2);
    flush_cmd = 1;
    redirect  = 32'h0040_0100;
    tick();
    chk("fl2_req_valid", 32'(s_rv), 32'h0);
    first_valid(14, off, fpc);
    chk("fl2_first_pc", fpc, 32'h0040_0100);
    chk("fl2_drops", 32'(drops), 32'd2);

    // Flush coinciding with a response while decode is ready.
    pcv_cmd = 0;
    ticks(8);
    lat = 1;
    pcv_cmd = 1;
    ticks(4);
    flush_cmd = 1;
    redirect  = 32'h0040_0200;
    tick();
    chk("flc_req_valid", 32'(s_rv), 32'h0);
    chk("flc_pc_ready", 32'(s_pr), 32'h0);
    tick();
    chk("flc_q_empty", 32'(s_iv), 32'h0);
    first_valid(6, off, fpc);
    chk("flc_first_pc", fpc, 32'h0040_0200);
    chk("flc_drops", 32'(drops), 32'd3);

    // Memory stall: request held with a stable address.
    ticks(3);
    rr_cmd = 0;
    stall_pc = pc_reg;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_rv && !s_pr && s_addr == stall_pc) cnt++;
    end
    chk("stall_hold", 32'(cnt), 32'd5);
    rr_cmd = 1;
    tick();
    chk("stall_resume", 32'(s_pr), 32'h1);
    ticks(4);

    // Mid-stream reset with both queues occupied.
    pcv_cmd = 0;
    ticks(6);
    lat = 3;
    pcv_cmd = 1;
    ir_cmd = 0;
    ticks(5);
    chk("pre_rst_valid", 32'(s_iv), 32'h1);
    rst_cmd = 1;
    tick();
    rst_cmd = 0;
    lat = 1;
    ir_cmd = 1;
    tick();
    chk("post_rst_valid", 32'(s_iv), 32'h0);
    chk("post_rst_busy", 32'(s_busy), 32'h0);
    chk("post_rst_addr", s_addr, 32'h0040_0000);
    first_valid(8, off, fpc);
    chk("post_rst_lat", 32'(off), 32'd1);
    chk("post_rst_pc", fpc, 32'h0040_0000);
    ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage, directly downstream of the PC register.
- Takes the current PC through a valid/ready handshake and issues in-order word reads to instruction memory.
- Buffers the returned instructions, each paired with its PC, in a queue that feeds decode.
- Drops in-flight responses on a redirect (flush). Its pc_ready output is the PC register's update enable.

Parameters:
- XLEN, 32: address and instruction width.
- DEPTH, 4: credit limit, i.e. maximum of (outstanding requests + queued instructions). Must be ≥2 and a power of 2.
- RESET_PC, 32'h0040_0000: used only by the bench to seed the PC model. The block holds no PC state of its own.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- pc  in  XLEN  fetch address from the PC register.
- pc_valid  in  1  pc is valid.
- pc_ready  out  1  fetch accepted this cycle; the PC register advances only when this is high.
- flush  in  1  redirect pulse: discard all queued and in-flight work.
- imem_req_valid  out  1  read request to instruction memory.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  XLEN  {pc[XLEN-1:2],2'b00}.
- imem_rsp_valid  in  1  read data returned; responses are in order and always accepted.
- imem_rsp_data  in  XLEN  instruction word.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  decode consumes the head.
- instr  out  XLEN  head instruction.
- instr_pc  out  XLEN  PC of the head instruction.
- busy  out  1  inflight≠0 or queue non-empty.

Behaviour:
- Reset (synchronous, active-high, 1 cycle):
  - inflight=0, discard_cnt=0; tag FIFO and instruction queue empty.
  - instr_valid=0, busy=0.
  - pc_ready=0 and imem_req_valid=0 while reset is high.
  - instr/instr_pc read 0 after reset. They are don't-care whenever instr_valid=0.
- Credit: credit_ok = (inflight + q_count) < DEPTH. Both values are taken from registers; a same-cycle pop is not counted.
- Request issue (combinational):
  - imem_req_valid = pc_valid & credit_ok & ~flush & ~reset. It never depends on imem_req_ready.
  - pc_ready = imem_req_valid & imem_req_ready.
  - imem_addr follows pc with bits [1:0] forced to zero.
- On request handshake: push pc into the tag FIFO; inflight+1.
- On response:
  - Pop the tag FIFO; inflight-1.
  - If discard_cnt>0: drop the data and decrement discard_cnt.
  - Otherwise: push {tag,data} into the instruction queue.
- Latency: with a 1-cycle memory, a request at cycle N gives instr_valid at cycle N+2 (registered queue output).
- Sustained throughput is 1 instr/cycle with a 1-cycle memory when DEPTH≥4 and decode is always ready.
- Decode pop: instr_valid & instr_ready. Push and pop may occur in the same cycle; q_count is unchanged.
- Flush:
  - Clears the instruction queue at the clock edge; any same-cycle pop is irrelevant.
  - Forces imem_req_valid=0 and pc_ready=0 that cycle.
  - Sets discard_cnt = inflight after this cycle's response, i.e. inflight − imem_rsp_valid. That response is itself dropped, even if discard_cnt was 0.
  - The tag FIFO is not cleared; it stays aligned with the responses.
  - A flush while discard_cnt>0 recomputes discard_cnt by the same rule.
- Full: when credit_ok=0, no request is issued. The responses that arrive always fit, because credits were reserved at issue.
- Empty: instr_valid=0; instr_ready is ignored.
- Counter widths: $clog2(DEPTH+1) bits. Overflow/underflow is impossible by construction; add assertions for both.
- Memory side: the memory shares the same reset. No response may arrive for a request issued before reset. After reset the block assumes zero outstanding requests.

Decomposition:
- Package fetch_pkg holds:
  - the fetch-entry struct {pc, instr};
  - the counter-width localparam;
  - the default RESET_PC constant, shared with the PC register.
- Sub-module sync_fifo (WIDTH, DEPTH, synchronous active-high reset, push/pop/full/empty/count), instantiated twice:
  - tag FIFO, WIDTH=XLEN;
  - instruction queue, WIDTH=2*XLEN, with clear driven by flush.

Test Plan:
- Reset then streaming: PC model 0x0040_0000, +4 per pc_ready; 1-cycle memory; instr_ready=1 → instr_pc = 0x0040_0000, 0x0040_0004, … back-to-back from cycle 2. pc_ready stays high after the first cycle.
- Backpressure: instr_ready=0 with DEPTH=4 → exactly 4 requests issued, then pc_ready=0. Release instr_ready → order preserved, no loss or duplication.
- Flush with 2 requests in flight (3-cycle memory), PC redirected to 0x0040_0100 → both stale responses dropped, discard_cnt 2→0. The first instr_pc seen is 0x0040_0100.
- Flush coincident with a response and with instr_ready=1 → that response is dropped, the queue is empty next cycle, and no request is issued in the flush cycle.
- Memory stall: imem_req_ready=0 for 5 cycles → pc_ready=0 and the PC holds; imem_req_valid stays high with a stable imem_addr.
- Mid-stream reset with queue and tag FIFO non-empty → next cycle instr_valid=0, busy=0. The fetch sequence restarts cleanly from 0x0040_0000.
